// File: rtl/uart_fifo_if.sv
// Register bus bundle for the UART peripheral: write port, read port and
// registered read data. The bus master drives strobes/addresses/data and the
// peripheral returns rd_data_o.
interface uart_fifo_if;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        rd_en_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
        output rd_data_o
    );
endinterface

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, optional
// parity, 1 or 2 stop bits, sticky error flags and a maskable level interrupt.
module uart_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       uart_int_o,
    uart_fifo_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RESET = 16'(CLK_FREQ / UART_BPS);

    localparam logic [4:0] ADDR_CTRL    = 5'h00;
    localparam logic [4:0] ADDR_STATUS  = 5'h04;
    localparam logic [4:0] ADDR_BAUD    = 5'h08;
    localparam logic [4:0] ADDR_TX_DATA = 5'h0C;
    localparam logic [4:0] ADDR_RX_DATA = 5'h10;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Configuration and sticky flags
    logic [7:0]  ctrl;
    logic [15:0] baud_div;
    logic        overrun, parity_err, frame_err;

    // Register bus decode
    logic [4:0] wr_sel, rd_sel;
    logic       wr_ctrl, wr_status, wr_baud, tx_push;
    logic       unused_bits;

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_count;
    logic          tx_full, tx_empty, tx_push_ok, tx_pop;

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_count;
    logic          rx_full, rx_empty, rx_push, rx_push_ok, rx_pop_ok;

    // TX engine
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_stop2, tx_stop2_n, tx_stop_idx, tx_stop_idx_n;
    logic        tx_par_en, tx_par_en_n, tx_par_bit, tx_par_bit_n;
    logic        tx_line_n, tx_bit_end, tx_last_stop, tx_frame_go, tx_busy;

    // RX engine
    rx_state_t   rx_state, rx_state_n;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_par_en, rx_par_en_n, rx_par_odd, rx_par_odd_n;
    logic        rx_par_bit, rx_par_bit_n, rx_bit_end;
    logic        set_overrun, set_parity, set_frame;

    logic [31:0] status, rd_value;

    assign wr_sel      = bus.wr_addr_i[4:0];
    assign rd_sel      = bus.rd_addr_i[4:0];
    assign wr_ctrl     = bus.wr_en_i && (wr_sel == ADDR_CTRL);
    assign wr_status   = bus.wr_en_i && (wr_sel == ADDR_STATUS);
    assign wr_baud     = bus.wr_en_i && (wr_sel == ADDR_BAUD);
    assign tx_push     = bus.wr_en_i && (wr_sel == ADDR_TX_DATA);
    assign unused_bits = ^{bus.wr_addr_i[31:5], bus.rd_addr_i[31:5], bus.wr_data_i[31:16]};

    assign tx_full    = (tx_count == FULL_COUNT);
    assign tx_empty   = (tx_count == '0);
    assign rx_full    = (rx_count == FULL_COUNT);
    assign rx_empty   = (rx_count == '0);
    assign tx_push_ok = tx_push && !tx_full;
    assign rx_push_ok = rx_push && !rx_full;
    assign rx_pop_ok  = bus.rd_en_i && (rd_sel == ADDR_RX_DATA) && !rx_empty;
    assign tx_busy    = (tx_state != TX_IDLE);

    // Configuration registers; undersized divisors are clamped to 16 so a bit is always long enough to mid-sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= 8'h03;
            baud_div <= BAUD_RESET;
        end else begin
            if (wr_ctrl) ctrl <= bus.wr_data_i[7:0];
            if (wr_baud) baud_div <= (bus.wr_data_i[15:0] < 16'd16) ? 16'd16 : bus.wr_data_i[15:0];
        end
    end

    // Sticky error flags: write-1-to-clear, with a same-cycle hardware set taking priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun    <= (overrun    & ~(wr_status & bus.wr_data_i[5])) | set_overrun;
            parity_err <= (parity_err & ~(wr_status & bus.wr_data_i[6])) | set_parity;
            frame_err  <= (frame_err  & ~(wr_status & bus.wr_data_i[7])) | set_frame;
        end
    end

    // FIFO storage arrays need no reset; validity is tracked by the counts
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp] <= bus.wr_data_i[7:0];
        if (rx_push_ok) rx_mem[rx_wp] <= rx_shift;
    end

    // FIFO pointers and occupancy; full/empty are judged on the pre-edge counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)     tx_rp <= tx_rp + AW'(1);
            tx_count <= tx_count + CW'(tx_push_ok) - CW'(tx_pop);
            if (rx_push_ok) rx_wp <= rx_wp + AW'(1);
            if (rx_pop_ok)  rx_rp <= rx_rp + AW'(1);
            rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop_ok);
        end
    end

    assign tx_bit_end   = (tx_cnt == tx_div - 16'd1);
    assign tx_last_stop = (tx_state == TX_STOP) && tx_bit_end && (tx_stop_idx == tx_stop2);
    assign tx_frame_go  = ctrl[0] && !tx_empty && ((tx_state == TX_IDLE) || tx_last_stop);

    // TX state and frame registers; the serial line is registered so it is glitch-free and idles high from reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_div      <= 16'd16;
            tx_stop2    <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            uart_tx     <= 1'b1;
        end else begin
            tx_state    <= tx_state_n;
            tx_cnt      <= tx_cnt_n;
            tx_bit      <= tx_bit_n;
            tx_shift    <= tx_shift_n;
            tx_div      <= tx_div_n;
            tx_stop2    <= tx_stop2_n;
            tx_stop_idx <= tx_stop_idx_n;
            tx_par_en   <= tx_par_en_n;
            tx_par_bit  <= tx_par_bit_n;
            uart_tx     <= tx_line_n;
        end
    end

    // TX sequencing; a new frame may start straight out of the last stop bit so queued bytes go out back-to-back
    always_comb begin
        tx_state_n    = tx_state;
        tx_cnt_n      = tx_cnt;
        tx_bit_n      = tx_bit;
        tx_shift_n    = tx_shift;
        tx_div_n      = tx_div;
        tx_stop2_n    = tx_stop2;
        tx_stop_idx_n = tx_stop_idx;
        tx_par_en_n   = tx_par_en;
        tx_par_bit_n  = tx_par_bit;
        tx_pop        = 1'b0;
        tx_line_n     = 1'b1;
        case (tx_state)
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n    = tx_par_en ? TX_PARITY : TX_STOP;
                        tx_stop_idx_n = 1'b0;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n    = TX_STOP;
                    tx_cnt_n      = '0;
                    tx_stop_idx_n = 1'b0;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_n = '0;
                    if (tx_stop_idx == tx_stop2) tx_state_n = TX_IDLE;
                    else tx_stop_idx_n = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            default: begin
            end
        endcase
        if (tx_frame_go) begin
            tx_state_n   = TX_START;
            tx_cnt_n     = '0;
            tx_pop       = 1'b1;
            tx_shift_n   = tx_mem[tx_rp];
            tx_div_n     = baud_div;
            tx_stop2_n   = ctrl[4];
            tx_par_en_n  = (ctrl[3:2] == 2'b01) || (ctrl[3:2] == 2'b10);
            tx_par_bit_n = (^tx_mem[tx_rp]) ^ (ctrl[3:2] == 2'b10);
        end
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift_n[0];
            TX_PARITY: tx_line_n = tx_par_bit_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    // Two-flop synchroniser on the asynchronous serial input, plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state and frame registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_div     <= 16'd16;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_div     <= rx_div_n;
            rx_par_en  <= rx_par_en_n;
            rx_par_odd <= rx_par_odd_n;
            rx_par_bit <= rx_par_bit_n;
        end
    end

    assign rx_bit_end = (rx_cnt == rx_div - 16'd1);

    // RX sequencing: START is checked at half a bit, after which each full bit period lands mid-bit
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_div_n     = rx_div;
        rx_par_en_n  = rx_par_en;
        rx_par_odd_n = rx_par_odd;
        rx_par_bit_n = rx_par_bit;
        rx_push      = 1'b0;
        set_overrun  = 1'b0;
        set_parity   = 1'b0;
        set_frame    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (ctrl[1] && rx_prev && !rx_sync) begin
                    rx_state_n   = RX_START;
                    rx_cnt_n     = '0;
                    rx_div_n     = baud_div;
                    rx_par_en_n  = (ctrl[3:2] == 2'b01) || (ctrl[3:2] == 2'b10);
                    rx_par_odd_n = (ctrl[3:2] == 2'b10);
                end
            end
            RX_START: begin
                if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
                    else rx_bit_n = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_n     = '0;
                    rx_par_bit_n = rx_sync;
                    rx_state_n   = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_full) begin
                        set_overrun = 1'b1;
                    end else begin
                        rx_push    = 1'b1;
                        set_parity = rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd));
                        set_frame  = !rx_sync;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    assign status = {8'h00, 8'(rx_count), 8'(tx_count), frame_err, parity_err, overrun,
                     tx_busy, rx_empty, rx_full, tx_empty, tx_full};

    // Read mux; values are taken before this edge's writes so read-during-write sees the old contents
    always_comb begin
        rd_value = 32'h0;
        case (rd_sel)
            ADDR_CTRL:    rd_value = {24'h0, ctrl};
            ADDR_STATUS:  rd_value = status;
            ADDR_BAUD:    rd_value = {16'h0, baud_div};
            ADDR_RX_DATA: rd_value = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
            default:      rd_value = 32'h0;
        endcase
    end

    // Registered read data with one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rd_data_o <= 32'h0;
        else        bus.rd_data_o <= rd_value;
    end

    assign uart_int_o = (ctrl[5] & tx_empty & ~tx_busy) | (ctrl[6] & ~rx_empty) |
                        (ctrl[7] & (overrun | parity_err | frame_err));

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: register access, TX framing, RX framing
// and errors, FIFO limits, randomized loopback and mid-frame reset.
module tb_uart_fifo;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 115200;
    localparam int DEPTH    = 16;
    localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_BAUD = 32'h08,
                            A_TX = 32'h0C, A_RX = 32'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic uart_rx, uart_tx, uart_int_o;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Behavioural model: RX FIFO contents and sticky flags
    logic [7:0] rxq[$];
    logic m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

    uart_fifo_if bus();

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_fifo #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .uart_int_o(uart_int_o), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expStatus(input int txc);
        return {8'h00, 8'(rxq.size()), 8'(txc), m_ferr, m_perr, m_ovr, 1'b0,
                rxq.size() == 0, rxq.size() == DEPTH, txc == 0, txc == DEPTH};
    endfunction

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_en_i = 1'b1; bus.wr_addr_i = addr; bus.wr_data_i = data;
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, input logic pop, output logic [31:0] data);
        @(negedge clk);
        bus.rd_addr_i = addr; bus.rd_en_i = pop;
        @(negedge clk);
        data = bus.rd_data_o;
        bus.rd_en_i = 1'b0;
    endtask

    // Drive one serial frame into uart_rx and update the model with its expected outcome
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pm, input bit s2,
                                 input bit flip, input bit stopv, input int div);
        bit par_on;
        par_on = (pm == 2'b01) || (pm == 2'b10);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (div) @(negedge clk);
        end
        if (par_on) begin
            rx_drv = (^d) ^ (pm == 2'b10) ^ flip;
            repeat (div) @(negedge clk);
        end
        rx_drv = stopv;
        repeat (div) @(negedge clk);
        rx_drv = 1'b1;
        if (s2) repeat (div) @(negedge clk);
        repeat (4) @(negedge clk);
        if (rxq.size() == DEPTH) m_ovr = 1'b1;
        else begin
            rxq.push_back(d);
            if (par_on && flip) m_perr = 1'b1;
            if (!stopv) m_ferr = 1'b1;
        end
    endtask

    // Wait for a start bit on uart_tx and sample an 8N1 frame at bit centres
    task automatic captureTx(input int div, output logic [7:0] d, output bit ok,
                             output int start_cyc, output int waited);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        start_cyc = cyc;
        ok = (waited < 2000);
        repeat (div / 2) @(negedge clk);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            d[i] = uart_tx;
        end
        repeat (div) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  txq[$];
        bit          ok;
        int          st, prev_st, waited, guard, div, n;
        logic [1:0]  pm;
        bit          s2;

        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.rd_en_i = 1'b0; bus.rd_addr_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_rd", bus.rd_data_o, 32'h0);
        checkOutput("rst_int", 32'(uart_int_o), 32'd0);
        rst_n = 1'b1;
        readReg(A_STATUS, 1'b0, v); checkOutput("rst_status", v, 32'h0A);
        readReg(A_CTRL, 1'b0, v);   checkOutput("rst_ctrl", v, 32'h03);
        readReg(A_BAUD, 1'b0, v);   checkOutput("rst_baud", v, 32'(CLK_FREQ / UART_BPS));
        readReg(32'h14, 1'b0, v);   checkOutput("unmapped", v, 32'h0);

        // Read-during-write returns the old value
        @(negedge clk);
        bus.wr_en_i = 1'b1; bus.wr_addr_i = A_CTRL; bus.wr_data_i = 32'h83; bus.rd_addr_i = A_CTRL;
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        checkOutput("rdw_old", bus.rd_data_o, 32'h03);
        readReg(A_CTRL, 1'b0, v); checkOutput("rdw_new", v, 32'h83);

        // Baud divisor clamping with random values
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(40, 0);
            writeReg(A_BAUD, 32'(n));
            readReg(A_BAUD, 1'b0, v);
            checkOutput("baud_clamp", v, (n < 16) ? 32'd16 : 32'(n));
        end
        writeReg(A_BAUD, 32'd16);

        // Single TX frame 0xA5, 8N1, txe interrupt
        writeReg(A_CTRL, 32'h23);
        checkOutput("txe_int_idle", 32'(uart_int_o), 32'd1);
        writeReg(A_TX, 32'hA5);
        captureTx(16, b, ok, st, waited);
        checkOutput("tx_start_lat", 32'(waited <= 2), 32'd1);
        checkOutput("tx_frame_ok", 32'(ok), 32'd1);
        checkOutput("tx_byte", 32'(b), 32'hA5);
        checkOutput("txe_int_busy", 32'(uart_int_o), 32'd0);
        repeat (16) @(negedge clk);
        checkOutput("txe_int_after", 32'(uart_int_o), 32'd1);

        // Fill TX FIFO with tx disabled, 17th byte dropped, then back-to-back frames
        writeReg(A_CTRL, 32'h02);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (txq.size() < DEPTH) txq.push_back(b);
            writeReg(A_TX, {24'h0, b});
        end
        readReg(A_STATUS, 1'b0, v); checkOutput("tx_fill_status", v, expStatus(DEPTH));
        writeReg(A_CTRL, 32'h03);
        prev_st = 0;
        for (int i = 0; i < DEPTH; i++) begin
            captureTx(16, b, ok, st, waited);
            checkOutput("tx_fifo_byte", 32'(b), 32'(txq.pop_front()));
            if (i > 0) checkOutput("tx_gap", 32'(st - prev_st), 32'd160);
            prev_st = st;
        end
        repeat (16) @(negedge clk);
        readReg(A_STATUS, 1'b0, v); checkOutput("tx_drain_status", v, expStatus(0));

        // RX with even parity and two stop bits; then a parity error and its W1C
        writeReg(A_CTRL, 32'h17);
        applyStimulus(8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 16);
        readReg(A_STATUS, 1'b0, v); checkOutput("rx_par_ok_status", v, expStatus(0));
        readReg(A_RX, 1'b1, v);     checkOutput("rx_byte", v, 32'(rxq.pop_front()));
        readReg(A_STATUS, 1'b0, v); checkOutput("rx_empty_status", v, expStatus(0));
        readReg(A_RX, 1'b0, v);     checkOutput("rx_read_empty", v, 32'h0);
        applyStimulus(8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 16);
        readReg(A_STATUS, 1'b0, v); checkOutput("rx_perr_status", v, expStatus(0));
        readReg(A_RX, 1'b1, v);     checkOutput("rx_perr_byte", v, 32'(rxq.pop_front()));
        writeReg(A_STATUS, 32'h40); m_perr = 1'b0;
        readReg(A_STATUS, 1'b0, v); checkOutput("rx_perr_clear", v, expStatus(0));

        // RX overrun: 17 frames with no reads
        writeReg(A_CTRL, 32'h82);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'($urandom), 2'b00, 1'b0, 1'b0, 1'b1, 16);
        readReg(A_STATUS, 1'b0, v); checkOutput("ovr_status", v, expStatus(0));
        checkOutput("ovr_int", 32'(uart_int_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            readReg(A_RX, 1'b1, v);
            checkOutput("ovr_byte", v, 32'(rxq.pop_front()));
        end
        writeReg(A_STATUS, 32'h20); m_ovr = 1'b0;
        readReg(A_STATUS, 1'b0, v); checkOutput("ovr_clear", v, expStatus(0));
        checkOutput("ovr_int_clear", 32'(uart_int_o), 32'd0);

        // Short glitch is a false start; then a frame with a low stop bit
        writeReg(A_CTRL, 32'h02);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (48) @(negedge clk);
        readReg(A_STATUS, 1'b0, v); checkOutput("glitch_status", v, expStatus(0));
        applyStimulus(8'($urandom), 2'b00, 1'b0, 1'b0, 1'b0, 16);
        readReg(A_STATUS, 1'b0, v); checkOutput("ferr_status", v, expStatus(0));
        readReg(A_RX, 1'b1, v);     checkOutput("ferr_byte", v, 32'(rxq.pop_front()));
        writeReg(A_STATUS, 32'h80); m_ferr = 1'b0;

        // Randomized loopback: TX output feeds RX with random divisor, parity and stop bits
        loop_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            div = $urandom_range(48, 16);
            pm  = 2'($urandom);
            s2  = 1'($urandom);
            n   = $urandom_range(10, 3);
            writeReg(A_BAUD, 32'(div));
            writeReg(A_CTRL, {27'h0, s2, pm, 2'b11});
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                rxq.push_back(b);
                writeReg(A_TX, {24'h0, b});
            end
            guard = 0;
            do begin
                readReg(A_STATUS, 1'b0, v);
                guard++;
            end while ((v[1] !== 1'b1 || v[4] !== 1'b0) && guard < 10000);
            checkOutput("loop_idle", 32'(guard < 10000), 32'd1);
            repeat (8) @(negedge clk);
            readReg(A_STATUS, 1'b0, v); checkOutput("loop_status", v, expStatus(0));
            while (rxq.size() > 0) begin
                readReg(A_RX, 1'b1, v);
                checkOutput("loop_byte", v, 32'(rxq.pop_front()));
            end
        end
        loop_en = 1'b0;

        // Reset in the middle of a TX frame
        writeReg(A_BAUD, 32'd16);
        writeReg(A_CTRL, 32'h03);
        writeReg(A_TX, 32'h00);
        repeat (40) @(negedge clk);
        checkOutput("pre_rst_tx", 32'(uart_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        readReg(A_STATUS, 1'b0, v); checkOutput("rst_mid_status", v, 32'h0A);
        readReg(A_CTRL, 1'b0, v);   checkOutput("rst_mid_ctrl", v, 32'h03);
        checkOutput("rst_mid_tx_idle", 32'(uart_tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised memory-mapped UART peripheral for the RISC-V SoC. It extends the single-buffer UART with the following:
- TX and RX FIFOs of configurable depth.
- A runtime-programmable baud divisor.
- Optional even or odd parity and 1 or 2 stop bits.
- Sticky error flags and a maskable level interrupt.

It sits on the peripheral bus beside the timer and GPIO. It uses the same write/read register port style.

## Interface
- CLK_FREQ, 50_000_000: system clock in Hz.
- UART_BPS, 115200: reset baud rate. BAUD_DIV resets to CLK_FREQ/UART_BPS.
- FIFO_DEPTH, 16: entries per FIFO. Must be a power of 2, ≥2, ≤128.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output. Idle high.
- wr_en_i  in  1  register write strobe.
- wr_addr_i  in  32  write address. Only [4:0] is decoded.
- wr_data_i  in  32  write data.
- rd_en_i  in  1  read strobe. Qualifies FIFO pop side effects.
- rd_addr_i  in  32  read address. Only [4:0] is decoded.
- rd_data_o  out  32  registered read data.
- uart_int_o  out  1  level interrupt.

## Operation
Register map:
- 0x00 CTRL (RW), reset 0x3:
  - [0] tx_en, [1] rx_en.
  - [3:2] parity: 00 or 11 none, 01 even, 10 odd.
  - [4] stop2.
  - [5] txe_ie, [6] rxne_ie, [7] err_ie.
- 0x04 STATUS:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy.
  - [5] overrun, [6] parity_err, [7] frame_err. These three are sticky and write-1-to-clear.
  - [15:8] tx_count, [23:16] rx_count.
  - Writes to other bits are ignored.
- 0x08 BAUD_DIV (RW), [15:0]. Written values <16 are stored as 16.
- 0x0C TX_DATA (WO): a write pushes wr_data_i[7:0]. A write while tx_full is dropped silently. Reads return 0.
- 0x10 RX_DATA (RO): returns {24'h0, head} or 0 when empty. rd_en_i with this address pops one entry if not empty.
- Other addresses read 0 and ignore writes.

TX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
- IDLE leaves when tx_en=1 and the FIFO is not empty. The head is popped and BAUD_DIV is latched for the whole frame.
- Every bit lasts the latched divisor in clk cycles.
- DATA shifts 8 bits, LSB first.
- PARITY is skipped when parity is none.
- STOP lasts 1 or 2 bits per stop2, which is latched at frame start.
- Clearing tx_en mid-frame completes the current frame, then holds IDLE.
- tx_busy is 1 whenever the state is not IDLE.

RX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
- uart_rx passes through a 2-flop synchroniser. A falling edge in IDLE with rx_en=1 enters START.
- START samples at div/2. If the line is high it is a false start and the FSM returns to IDLE with no flags set.
- Each later bit is sampled at div/2 of that bit.
- Only the first stop bit is checked.
- At STOP sample:
  - If the RX FIFO is full, the byte is dropped and overrun is set.
  - Otherwise the byte is pushed. parity_err is set on mismatch; frame_err is set if the stop bit is 0. The byte is stored in both cases.

Interrupt: uart_int_o = (txe_ie & tx_empty & !tx_busy) | (rxne_ie & !rx_empty) | (err_ie & (overrun|parity_err|frame_err)).

## Timing
- Reset values:
  - uart_tx=1, rd_data_o=0, uart_int_o=0.
  - Both FIFOs empty, all sticky flags 0.
  - CTRL=0x3, BAUD_DIV=CLK_FREQ/UART_BPS.
  - Both FSMs in IDLE.
- rd_data_o is updated the cycle after rd_addr_i is sampled (1-cycle latency). The pop takes effect in that same edge.
- Read-during-write to the same register returns the pre-write value.
- A TX_DATA write into an empty FIFO while idle drives the start bit within 2 cycles.
- BAUD_DIV writes mid-frame take effect at the next frame.
- Simultaneous FIFO push and pop:
  - Both succeed when the FIFO is neither full nor empty.
  - On empty, the push is accepted and the pop returns 0.
  - On full, the pop succeeds and the push is dropped (full is judged on the pre-edge state).
- Simultaneous W1C and hardware set of the same flag: the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. Counts run 0..FIFO_DEPTH.
- Reset mid-frame: uart_tx goes high immediately and the partial frame is lost.

## Test plan
- BAUD_DIV=16, parity none: write 0xA5. uart_tx shows start, then 1,0,1,0,0,1,0,1, then stop, each 16 cycles. tx_empty interrupt asserts after stop.
- Push 17 bytes with FIFO_DEPTH=16 while tx_en=0. tx_count=16 and the 17th byte is dropped. Set tx_en: 16 frames go out back-to-back, with no idle gap beyond the stop bit.
- Even parity, stop2: drive RX frame 0x3C with correct parity. rx_count=1, RX_DATA read returns 0x3C, then rx_empty=1. Repeat with a flipped parity bit: byte stored, parity_err=1. Write 0x40 to STATUS: flag cleared.
- Drive 17 RX frames without reading. overrun=1, FIFO holds the first 16 in order, interrupt asserted with err_ie=1.
- Drive a 0 glitch of div/4 cycles on uart_rx. No byte is received and no flag is set. Drive a stop bit low: frame_err=1, byte stored.
- Assert rst_n low mid-TX-frame. uart_tx=1 within the same cycle, STATUS=0x0A (tx_empty, rx_empty), CTRL=0x3.
